tx_ring_ctrl: RTL and testbench

TX_RING_CTRL -- requirements
Module: tx_ring_ctrl

---
 rtl/tx_ring_ctrl_if.sv | 43 ++++
 rtl/tx_ring_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tx_ring_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_ring_ctrl_if.sv
// tx_ring_ctrl_if: groups the producer word stream, the consumer byte stream and
// the occupancy status of tx_ring_ctrl.
//
// Handshake rule, identical on both streams: a transfer happens on a rising clk
// edge where valid and ready are both 1. The source may not drop valid or change
// its payload while valid=1 and ready=0. ready may depend combinationally on
// state, but never on valid.
//
// Signals:
//   in_data/in_keep/in_last/in_valid -> ring    producer word, byte-keep, frame end
//   in_ready                         <- ring    ring can take a word
//   out_data/out_last/out_valid      <- ring    transmit byte, frame end, valid
//   out_ready                        -> ring    consumer takes the byte
//   level / frames_pending           <- ring    words stored / complete frames waiting
interface tx_ring_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 48,
  parameter int BE_WIDTH   = 6
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [BE_WIDTH-1:0]   in_keep;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   frames_pending;

  // Producer/consumer side (the environment around the ring).
  modport master (
    output in_data, in_keep, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid, level, frames_pending
  );

  // Ring side.
  modport slave (
    input  in_data, in_keep, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid, level, frames_pending
  );
endinterface

// File: rtl/tx_ring_ctrl.sv
// tx_ring_ctrl: word-wide transmit ring feeding a byte serializer.
// Producer words (6 bytes, most significant byte first) are stored in a
// 2**ADDR_WIDTH-deep ring together with their byte count and frame-end flag.
// A serializer starts a frame once a complete frame is stored, or once the
// ring is full (cut-through, so frames longer than the ring cannot deadlock).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   bus        tx_ring_ctrl_if.slave (word input, byte output, status)
//   state_dbg  serializer state: 0 IDLE, 1 FETCH, 2 SHIFT
module tx_ring_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 48,
  parameter int BE_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                rst,
  tx_ring_ctrl_if.slave       bus,
  output logic [1:0]          state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(BE_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         cnt;
    logic                  last;
  } entry_t;

  state_t state, state_nxt;

  entry_t mem [DEPTH];
  entry_t wr_entry, rd_entry;

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, pend;
  logic                  full, empty, push, fetch;
  logic                  pend_inc, pend_dec;
  logic [CW-1:0]         keep_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  last_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign fetch        = (state == FETCH);

  // Byte count of a last word; keep is contiguous from the top bit, and an
  // all-zero keep still sends the top byte so the frame end is never lost.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      keep_cnt = keep_cnt + CW'(bus.in_keep[i]);
    end
    if (bus.in_keep == '0) begin
      keep_cnt = CW'(1);
    end
  end

  always_comb begin
    wr_entry.data = bus.in_data;
    wr_entry.cnt  = bus.in_last ? keep_cnt : CW'(BE_WIDTH);
    wr_entry.last = bus.in_last;
  end

  // Storage is not reset. A full ring blocks pushes, so a write never lands
  // on an unfetched slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // A frame stops being pending when its last word is fetched.
  assign pend_inc = push && bus.in_last;
  assign pend_dec = fetch && rd_entry.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({pend_inc, pend_dec})
        2'b10:   pend <= pend + 1'b1;
        2'b01:   pend <= pend - 1'b1;
        default: pend <= pend;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((pend != '0) || full) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bus.out_ready && (cnt_q == CW'(1))) begin
          // Continue a frame only while words are on hand; otherwise wait in
          // IDLE for the frame end or a full ring.
          state_nxt = (!last_q && !empty) ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The fetched word lands directly in the shift register (registered read).
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (fetch) begin
      shift_q <= rd_entry.data;
      cnt_q   <= rd_entry.cnt;
      last_q  <= rd_entry.last;
    end else if ((state == SHIFT) && bus.out_ready) begin
      shift_q <= shift_q << 8;
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign bus.out_valid      = (state == SHIFT);
  assign bus.out_data       = shift_q[DATA_WIDTH-1 -: 8];
  assign bus.out_last       = (state == SHIFT) && (cnt_q == CW'(1)) && last_q;
  assign bus.level          = wr_ptr - rd_ptr;
  assign bus.frames_pending = pend;
  assign state_dbg          = state;

endmodule

// File: tb/tb_tx_ring_ctrl.sv
// Bench for tx_ring_ctrl. A byte-level model (expected queue of {last, byte})
// is filled from every accepted producer word and drained by every accepted
// output byte; directed literal checks pin the model in each scenario.
module tb_tx_ring_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 48;
  localparam int BW    = 6;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  tx_ring_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  logic rand_en   = 1'b0;
  logic rand_bit  = 1'b0;
  logic ready_dir = 1'b0;

  assign bus.out_ready = rand_en ? rand_bit : ready_dir;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  tx_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic       mon_en    = 1'b0;
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int byte_count(input logic [BW-1:0] keep, input logic last);
    int n;
    n = 0;
    if (!last) return BW;
    if (keep == '0) return 1;
    for (int i = 0; i < BW; i++) n += int'(keep[i]);
    return n;
  endfunction

  // Compare process: values seen at the falling edge are what the next rising
  // edge will act on.
  always @(negedge clk) begin
    int n;
    logic [8:0] exp_b;
    cyc++;
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        hold_prev = 1'b0;
        check("in_ready_in_reset", bus.in_ready, 1'b0);
      end else begin
        check("in_ready_vs_level", bus.in_ready, (bus.level < 6'(DEPTH)));
        check("level_le_depth", (bus.level <= 6'(DEPTH)), 1'b1);
        if (hold_prev) begin
          check("hold_valid", bus.out_valid, 1'b1);
          check("hold_payload", {bus.out_last, bus.out_data}, hold_val);
        end
        if (bus.in_valid && bus.in_ready) begin
          n = byte_count(bus.in_keep, bus.in_last);
          for (int i = 0; i < n; i++) begin
            exp_q.push_back({bus.in_last && (i == n - 1), bus.in_data[DW-1-8*i -: 8]});
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          got_q.push_back({bus.out_last, bus.out_data});
          got_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("spare_byte", (exp_q.size() != 0), 1'b1);
          end else begin
            exp_b = exp_q.pop_front();
            check("byte", {bus.out_last, bus.out_data}, exp_b);
          end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        hold_val  = {bus.out_last, bus.out_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    int t;
    t = 0;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("push_in_ready_timeout", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !bus.out_valid && bus.level == '0) && t < budget) begin
      t++;
      @(negedge clk);
    end
    check("drain_done", (exp_q.size() == 0 && !bus.out_valid && bus.level == '0), 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word37(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'h80 | b, b, 8'h5A, 8'hA5, ~b, 8'(i * 3)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t;
    int lasts;
    logic [8:0]    exp36 [9];
    logic [BW-1:0] keep_tab [5];
    logic [BW-1:0] keep38 [3];
    int            len38 [3];

    exp36    = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5, 9'h0B0, 9'h0B1, 9'h1B2};
    keep_tab = '{6'b111111, 6'b110000, 6'b100000, 6'b111110, 6'b000000};
    keep38   = '{6'b111111, 6'b111100, 6'b110000};
    len38    = '{1, 5, 12};

    bus.in_data  = '0;
    bus.in_keep  = '0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_level", bus.level, 6'd0);
    check("rst_frames_pending", bus.frames_pending, 6'd0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    mon_en = 1'b1;
    rst    = 1'b0;
    tick();
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    // Two words, second last with three bytes kept
    ready_dir = 1'b1;
    got_q.delete();
    got_cyc.delete();
    push_word(48'hA0A1A2A3A4A5, 6'b000000, 1'b0);
    push_word(48'hB0B1B2B3B4B5, 6'b111000, 1'b1);
    check("fp_after_frame", bus.frames_pending, 6'd1);
    wait_drain(200);
    check("fp_after_drain", bus.frames_pending, 6'd0);
    check("two_word_count", got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size()) check("two_word_byte", got_q[i], exp36[i]);
    end
    if (got_q.size() == 9) check("two_word_span_le_9", (got_cyc[8] - got_cyc[0] <= 9), 1'b1);

    // Last word with empty keep
    got_q.delete();
    push_word({8'h5A, 40'h0102030405}, 6'b000000, 1'b1);
    wait_drain(200);
    check("keep0_count", got_q.size(), 1);
    if (got_q.size() > 0) check("keep0_byte", got_q[0], 9'h15A);

    // Fill with no frame end, consumer stalled: cut-through start
    ready_dir = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(word37(i), 6'b000000, 1'b0);
    check("full_level", bus.level, 6'd32);
    check("full_in_ready", bus.in_ready, 1'b0);
    check("full_out_valid_before", bus.out_valid, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 10) begin
      tick();
      t++;
    end
    check("cut_through_valid", bus.out_valid, 1'b1);
    check("cut_through_data", bus.out_data, 8'h80);
    check("cut_through_last", bus.out_last, 1'b0);
    ready_dir = 1'b1;
    wait_drain(2000);
    push_word(48'hE0E1E2E3E4E5, 6'b111111, 1'b1);
    wait_drain(200);

    // Random consumer stalls over three frames
    got_q.delete();
    rand_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < len38[f]; w++) begin
        push_word({8'(f), 8'(w), 32'h12345678 + 32'(w * 37)}, keep38[f], (w == len38[f] - 1));
      end
    end
    wait_drain(3000);
    rand_en = 1'b0;
    check("three_frame_count", got_q.size(), 102);

    // Forty single-word frames, continuous push and pop
    got_q.delete();
    ready_dir = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push_word({8'hF0 ^ 8'(k), 8'(k), 32'hC0DEC0DE}, keep_tab[k % 5], 1'b1);
    end
    wait_drain(2000);
    check("stream_count", got_q.size(), 120);
    lasts = 0;
    foreach (got_q[i]) lasts += int'(got_q[i][8]);
    check("stream_frames", lasts, 40);

    // Reset after byte 3 of a 4-word frame
    got_q.delete();
    for (int w = 0; w < 4; w++) push_word({8'h70 + 8'(w), 40'h1111111111}, 6'b111111, (w == 3));
    t = 0;
    while (got_q.size() < 3 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("rst_point_bytes", got_q.size(), 3);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_level", bus.level, 6'd0);
    check("midrst_frames_pending", bus.frames_pending, 6'd0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_out_valid", bus.out_valid, 1'b0);
    repeat (20) tick();
    check("no_bytes_after_rst", got_q.size(), 3);

    // Recovery frame after reset
    push_word(48'h313233343536, 6'b111111, 1'b1);
    wait_drain(200);
    check("recovery_count", got_q.size(), 9);
    if (got_q.size() == 9) check("recovery_first", got_q[3], 9'h031);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
